// File: rtl/regfile_mp_if.sv
// Bundle of all non-clock signals of the multi-port register file.
//   master : drives writes, read addresses and issue; sees read data and state
//   slave  : the register file side
// Write ports: we0/waddr0/wdata0 (ALU), we1/waddr1/wdata1 (load, higher priority).
// Read ports:  rs / rd_data / rd_busy, port k packed at [k*width +: width].
// Scoreboard:  issue_valid/issue_dest in, busy vector out.
// Debug:       last_wr_addr / last_wr_valid.
interface regfile_mp_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_RD        = 2
);
  logic                              we0;
  logic [ADDRESS_WIDTH-1:0]          waddr0;
  logic [DATA_WIDTH-1:0]             wdata0;
  logic                              we1;
  logic [ADDRESS_WIDTH-1:0]          waddr1;
  logic [DATA_WIDTH-1:0]             wdata1;
  logic [NUM_RD*ADDRESS_WIDTH-1:0]   rs;
  logic [NUM_RD*DATA_WIDTH-1:0]      rd_data;
  logic [NUM_RD-1:0]                 rd_busy;
  logic                              issue_valid;
  logic [ADDRESS_WIDTH-1:0]          issue_dest;
  logic [NUM_REGS-1:0]               busy;
  logic [ADDRESS_WIDTH-1:0]          last_wr_addr;
  logic                              last_wr_valid;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, rs, issue_valid, issue_dest,
    input  rd_data, rd_busy, busy, last_wr_addr, last_wr_valid
  );
  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, rs, issue_valid, issue_dest,
    output rd_data, rd_busy, busy, last_wr_addr, last_wr_valid
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports, two
// synchronous write ports (port 1 wins on address collision), optional
// same-cycle write-to-read bypass, per-register busy scoreboard and a
// registered last-write tracker.
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : regfile_mp_if.slave (write ports, read ports, issue, busy, last_wr)
module regfile_mp #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_RD        = 2,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  // Index width into storage; only used after the range check has passed.
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AW:0] LIMIT = (AW+1)'(NUM_REGS);

  // Address maps to a real, writable/readable register.
  function automatic logic live(input logic [AW-1:0] a);
    return ({1'b0, a} < LIMIT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DW-1:0]       regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [AW-1:0]       last_addr_q;
  logic                last_valid_q;
  logic                wr0_ok, wr1_ok;

  assign wr0_ok = bus.we0 && live(bus.waddr0);
  assign wr1_ok = bus.we1 && live(bus.waddr1);

  // Storage: port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      if (wr0_ok) regs[bus.waddr0[IW-1:0]] <= bus.wdata0;
      if (wr1_ok) regs[bus.waddr1[IW-1:0]] <= bus.wdata1;
    end
  end

  // Scoreboard: a new issue to r outranks a completing write to r, since the
  // issued instruction is the newer producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (bus.issue_valid && bus.issue_dest == AW'(r) && !((ZERO_REG != 0) && r == 0))
          busy_q[r] <= 1'b1;
        else if ((bus.we0 && bus.waddr0 == AW'(r)) || (bus.we1 && bus.waddr1 == AW'(r)))
          busy_q[r] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
    end else if (wr1_ok) begin
      last_addr_q  <= bus.waddr1;
      last_valid_q <= 1'b1;
    end else if (wr0_ok) begin
      last_addr_q  <= bus.waddr0;
      last_valid_q <= 1'b1;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.last_wr_addr  = last_addr_q;
  assign bus.last_wr_valid = last_valid_q;

  // Read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          byp0, byp1;
    logic [DW-1:0] data;
    logic          rbusy;

    assign a    = bus.rs[k*AW +: AW];
    assign byp1 = (BYPASS != 0) && bus.we1 && (bus.waddr1 == a);
    assign byp0 = (BYPASS != 0) && bus.we0 && (bus.waddr0 == a);

    always_comb begin
      data  = '0;
      rbusy = 1'b0;
      if (live(a)) begin
        if (byp1)      data = bus.wdata1;
        else if (byp0) data = bus.wdata0;
        else           data = regs[a[IW-1:0]];
        // A write landing this cycle resolves the hazard for the reader.
        rbusy = busy_q[a[IW-1:0]] && !(byp0 || byp1);
      end
    end

    assign bus.rd_data[k*DW +: DW] = data;
    assign bus.rd_busy[k]          = rbusy;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the processor datapath, successor to the current two-read/one-write file. It provides NUM_RD combinational read ports, two prioritised synchronous write ports and optional same-cycle write-to-read bypass. It also keeps a per-register busy scoreboard for hazard detection and a registered last-write tracker for external debug.

## Interface
- DATA_WIDTH, 32, bits per register
- ADDRESS_WIDTH, 5, register address bits
- NUM_REGS, 32, register count (≤ 2^ADDRESS_WIDTH)
- NUM_RD, 2, read ports (1..4)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1: same-cycle write data forwarded to reads

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- we0  in  1  write enable, port 0 (ALU path)
- waddr0  in  ADDRESS_WIDTH  write address, port 0
- wdata0  in  DATA_WIDTH  write data, port 0
- we1  in  1  write enable, port 1 (load path, higher priority)
- waddr1  in  ADDRESS_WIDTH  write address, port 1
- wdata1  in  DATA_WIDTH  write data, port 1
- rs  in  NUM_RD*ADDRESS_WIDTH  read addresses, port k at bits [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_WIDTH  read data, same packing
- rd_busy  out  NUM_RD  busy bit of each read address
- issue_valid  in  1  an instruction with destination is issued
- issue_dest  in  ADDRESS_WIDTH  its destination register
- busy  out  NUM_REGS  scoreboard vector
- last_wr_addr  out  ADDRESS_WIDTH  address of most recent committed write
- last_wr_valid  out  1  last_wr_addr holds a real write

## Operation
- Reset (rst=1, any time, no clock needed): all registers 0, busy all 0, last_wr_addr 0, last_wr_valid 0. Mid-cycle assertion discards in-flight writes and issues.
- Write: on posedge, if weN and address < NUM_REGS, register[waddrN] ← wdataN. Both ports to same address: port 1 wins. Different addresses: both commit.
- ZERO_REG=1: writes to address 0 dropped (no effect on busy/last_wr); reads of 0 return 0.
- Address ≥ NUM_REGS: write dropped; read returns 0; rd_busy 0.
- Read: combinational from rs. BYPASS=1: if an enabled write port targets the read address this cycle, return its wdata (port 1 over port 0); else stored value. BYPASS=0: stored value only (new data visible next cycle).
- Scoreboard, per register r, next state:
  - set if issue_valid && issue_dest==r;
  - else clear if (we0 && waddr0==r) || (we1 && waddr1==r);
  - else hold.
  - Set dominates clear (newer producer). Register 0 never set when ZERO_REG=1.
- rd_busy[k] = busy[rs_k], masked to 0 if BYPASS=1 and a write to rs_k occurs this cycle.
- last_wr tracker: on posedge with at least one committed write, last_wr_addr ← waddr1 if port 1 committed, else waddr0; last_wr_valid ← 1. Cycles with no committed write hold both.

## Timing
- Write latency: 1 cycle to storage; 0 cycles to read port with BYPASS=1.
- Read: purely combinational, no clock latency.
- busy/last_wr update on the edge after the causing inputs.
- No handshakes; all inputs sampled every cycle.

## Test plan
- Reset: write x5=0xDEADBEEF, assert rst asynchronously mid-cycle → rd_data of x5 = 0 immediately; busy = 0, last_wr_valid = 0.
- Dual write collision: we0/we1 both to x7 with 0x11 / 0x22 → next cycle x7 = 0x22; last_wr_addr = 7.
- Bypass: BYPASS=1, we0 x3=0xA5A5A5A5 and rs0=3 same cycle → rd_data0 = 0xA5A5A5A5 that cycle. BYPASS=0 → old value, new value next cycle.
- Zero register: we1 x0=0xFFFFFFFF, issue x0 → x0 reads 0, busy[0]=0, last_wr unchanged.
- Scoreboard: issue x9 → busy[9]=1 next cycle. Write x9 with issue x9 same cycle → stays 1. Write x9 alone → 0. rd_busy on rs1=9 tracks this, masked during bypassed write.
- Parameter sweep: NUM_RD=4, NUM_REGS=16 with ADDRESS_WIDTH=5; write addr 20 dropped, read addr 20 → 0; all four ports read distinct registers correctly.
